stage_sequencer: RTL

- Parametrised, generalised stage/command progression controller for the serial (NSHIFT bits/cycle) CPU core.
- Runs each instruction through up to NUM_STAGES programmable stages. Each stage can be enabled, repeated, made to issue a TX command, and/or made to wait for RX reply data.
- Tracks up to MAX_OUTSTANDING in-flight reads instead of a single one.
- Sits between decode and the ALU/TX/RX interfaces, replacing hard-coded addr/data/rotate stage logic.

---
 rtl/stage_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Steps one instruction of the serial CPU core through up to NUM_STAGES
//   programmable stages. Each enabled stage may repeat, may send one TX
//   command per execution, and may hold off the ALU until RX reply data
//   arrives. The block also counts reads that have been issued but not yet
//   completed by rx_done.
//
// Handshakes:
//   inst_valid / inst_done : the requester holds inst_valid and all stage_*
//     fields stable until inst_done pulses for one cycle. The cycle after
//     inst_done (DONE) ignores inst_valid, so the requester can drop it.
//   tx_command_valid / tx_command_started : a command transfers in any cycle
//     where both are high. Valid stays high until it is accepted, and
//     tx_command stays stable meanwhile.
//   alu_en / op_done : op_done is acted on only in cycles where alu_en is high.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   inst_valid, skip        instruction present / finish without executing
//   stage_en                per-stage enable
//   stage_repeat            per-stage extra executions (REPEAT_BITS each)
//   stage_cmd_en            per-stage "send a TX command"
//   stage_cmd_read          per-stage "that command is a read"
//   stage_cmd               per-stage TX header code (CMD_BITS each)
//   stage_wait_rx           per-stage "ALU waits for rx_data_valid"
//   op_done                 ALU finished current operation
//   tx_command_valid/_cmd   command request and header
//   tx_command_started      TX accepted the command
//   rx_data_valid, rx_done  reply payload valid / reply complete
//   alu_en                  ALU may advance this cycle
//   stage, repeat_idx       current stage and repetition
//   first_rep               repeat_idx == 0
//   inst_done               one-cycle completion pulse
//   outstanding             reads in flight
//   busy                    sequencer not idle
//   dbg_state               FSM state (0 IDLE, 1 RUN, 2 DONE)
module stage_sequencer #(
  parameter int NUM_STAGES      = 4,
  parameter int REPEAT_BITS     = 2,
  parameter int CMD_BITS        = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              inst_valid,
  input  logic                              skip,
  input  logic [NUM_STAGES-1:0]             stage_en,
  input  logic [NUM_STAGES*REPEAT_BITS-1:0] stage_repeat,
  input  logic [NUM_STAGES-1:0]             stage_cmd_en,
  input  logic [NUM_STAGES-1:0]             stage_cmd_read,
  input  logic [NUM_STAGES*CMD_BITS-1:0]    stage_cmd,
  input  logic [NUM_STAGES-1:0]             stage_wait_rx,
  input  logic                              op_done,
  output logic                              tx_command_valid,
  output logic [CMD_BITS-1:0]               tx_command,
  input  logic                              tx_command_started,
  input  logic                              rx_data_valid,
  input  logic                              rx_done,
  output logic                              alu_en,
  output logic [$clog2(NUM_STAGES)-1:0]     stage,
  output logic [REPEAT_BITS-1:0]            repeat_idx,
  output logic                              first_rep,
  output logic                              inst_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                              busy,
  output logic [1:0]                        dbg_state
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic [REPEAT_BITS-1:0] repeat_idx_q, repeat_idx_d;
  logic                   cmd_issued_q, cmd_issued_d;
  logic [OW-1:0]          outstanding_q, outstanding_d;

  logic [SW-1:0]          first_stage;
  logic [SW-1:0]          next_stage;
  logic                   has_next;
  logic [REPEAT_BITS-1:0] cur_repeat;
  logic                   need_cmd;
  logic                   read_full;
  logic                   rd_accept;
  logic                   rd_retire;

  // Lowest enabled stage overall, and lowest enabled stage above the current
  // one. Scanning downwards leaves the lowest match in the variable last.
  always_comb begin
    first_stage = '0;
    next_stage  = '0;
    has_next    = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_en[i]) begin
        first_stage = SW'(i);
        if (i > int'(stage_q)) begin
          next_stage = SW'(i);
          has_next   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    stage_d          = stage_q;
    repeat_idx_d     = repeat_idx_q;
    cmd_issued_d     = cmd_issued_q;
    tx_command_valid = 1'b0;
    tx_command       = '0;
    alu_en           = 1'b0;
    inst_done        = 1'b0;
    rd_accept        = 1'b0;

    cur_repeat = stage_repeat[stage_q*REPEAT_BITS +: REPEAT_BITS];
    need_cmd   = stage_cmd_en[stage_q] && !cmd_issued_q;
    read_full  = stage_cmd_read[stage_q] && (outstanding_q == OW'(MAX_OUTSTANDING));

    unique case (state_q)
      IDLE: begin
        if (inst_valid) begin
          if (skip || (stage_en == '0)) begin
            inst_done = 1'b1;
            state_d   = DONE;
          end else begin
            state_d      = RUN;
            stage_d      = first_stage;
            repeat_idx_d = '0;
            cmd_issued_d = 1'b0;
          end
        end
      end
      RUN: begin
        tx_command_valid = need_cmd && !read_full;
        tx_command       = stage_cmd[stage_q*CMD_BITS +: CMD_BITS];
        // need_cmd stays high through the accept cycle, so the ALU starts
        // at the earliest one cycle after the command is taken.
        alu_en = !need_cmd && (!stage_wait_rx[stage_q] || rx_data_valid);
        if (tx_command_valid && tx_command_started) begin
          cmd_issued_d = 1'b1;
          rd_accept    = stage_cmd_read[stage_q];
        end
        if (alu_en && op_done) begin
          if (repeat_idx_q < cur_repeat) begin
            repeat_idx_d = repeat_idx_q + 1'b1;
            cmd_issued_d = 1'b0;
          end else if (has_next) begin
            stage_d      = next_stage;
            repeat_idx_d = '0;
            cmd_issued_d = 1'b0;
          end else begin
            inst_done = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // rx_done with nothing in flight is a protocol error and is dropped.
  assign rd_retire = rx_done && (outstanding_q != '0);

  always_comb begin
    outstanding_d = outstanding_q;
    if (rd_accept && !rd_retire) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!rd_accept && rd_retire) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      stage_q       <= '0;
      repeat_idx_q  <= '0;
      cmd_issued_q  <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      repeat_idx_q  <= repeat_idx_d;
      cmd_issued_q  <= cmd_issued_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign stage       = stage_q;
  assign repeat_idx  = repeat_idx_q;
  assign first_rep   = (repeat_idx_q == '0);
  assign outstanding = outstanding_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule
